// File: rtl/bitmode_seq_if.sv
// -----------------------------------------------------------------------------
// bitmode_seq_if
// Video RAM port bundle between the bitmode sequencer (master) and the video
// RAM arbiter (slave).
//
// Handshake: the master raises RAM_REQ with RAM_WE/RAM_ADDR/RAM_WDATA and holds
// all four stable until it samples RAM_GNT=1 on a rising clock edge while
// RAM_REQ=1. That edge completes the transfer, and the master drops RAM_REQ
// on the same edge. RAM_GNT is a one-cycle pulse. A grant seen while RAM_REQ=0
// is meaningless and is ignored. For a read, RAM_RDATA is valid in the cycle
// after the granting edge.
//
// Signals:
//   RAM_REQ    master->slave  port request
//   RAM_WE     master->slave  1=write cycle, qualified by RAM_REQ
//   RAM_ADDR   master->slave  byte address
//   RAM_WDATA  master->slave  write data
//   RAM_GNT    slave->master  one-cycle grant
//   RAM_RDATA  slave->master  read data (cycle after read grant)
// -----------------------------------------------------------------------------
interface bitmode_seq_if #(
    parameter int ADDR_W = 15
);
    logic              RAM_REQ;
    logic              RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [7:0]        RAM_WDATA;
    logic              RAM_GNT;
    logic [7:0]        RAM_RDATA;

    modport master (
        output RAM_REQ, RAM_WE, RAM_ADDR, RAM_WDATA,
        input  RAM_GNT, RAM_RDATA
    );

    modport slave (
        input  RAM_REQ, RAM_WE, RAM_ADDR, RAM_WDATA,
        output RAM_GNT, RAM_RDATA
    );
endinterface

// File: rtl/bitmode_seq.sv
// -----------------------------------------------------------------------------
// bitmode_seq
// Crystal Castles bitmode pixel access sequencer. Holds the X/Y pixel address
// registers and turns a CPU pixel read/write into a video RAM byte read or a
// read-modify-write of the selected nibble, then post-steps X/Y.
//
// Ports:
//   CLK10, RESETn         clock, asynchronous active-low reset
//   CPU_STB               one-cycle CPU bus cycle strobe (samples CPU inputs)
//   BITMDn                active-low bitmode window select
//   BA[1:0]               0=X, 1=Y, 2=pixel, 3=reserved
//   BRWn                  1=read, 0=write
//   BD_IN / BD_OUT        CPU write data / CPU read data
//   CPU_RDY               low stalls the CPU during a pixel access
//   XINCn, YINCn          active-low step enables
//   AXn, AYn              step direction, 1=+1, 0=-1
//   ram                   video RAM port (master side)
//   X, Y                  current pixel address registers
//   BUSY                  sequencer not idle
//   FSM_STATE             debug view of the sequencer state
// -----------------------------------------------------------------------------
module bitmode_seq #(
    parameter int ADDR_W     = 15,
    parameter bit HI_NIB_ODD = 1'b1
) (
    input  logic       CLK10,
    input  logic       RESETn,
    input  logic       CPU_STB,
    input  logic       BITMDn,
    input  logic [1:0] BA,
    input  logic       BRWn,
    input  logic [7:0] BD_IN,
    output logic [7:0] BD_OUT,
    output logic       CPU_RDY,
    input  logic       XINCn,
    input  logic       YINCn,
    input  logic       AXn,
    input  logic       AYn,
    bitmode_seq_if.master ram,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic       BUSY,
    output logic [2:0] FSM_STATE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        STEP    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    logic              rdy_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              is_wr;
    logic              sel_hi;   // selected nibble is bits [7:4]
    logic [3:0]        wn;

    logic              accept;
    logic              pix_go;
    logic              gnt_ok;
    logic [3:0]        rd_nib;
    logic [7:0]        merged;

    assign accept = (state == IDLE) && CPU_STB && !BITMDn;
    assign pix_go = accept && (BA == 2'd2);
    assign gnt_ok = ram.RAM_GNT && req_q;

    // Nibble of the byte arriving from RAM, and that byte with the selected
    // nibble replaced; the other nibble passes through untouched.
    assign rd_nib = sel_hi ? ram.RAM_RDATA[7:4] : ram.RAM_RDATA[3:0];
    assign merged = sel_hi ? {wn, ram.RAM_RDATA[3:0]} : {ram.RAM_RDATA[7:4], wn};

    // The stall must reach the CPU in the accepting cycle itself, so the
    // registered ready is gated combinationally by a pixel acceptance.
    assign CPU_RDY   = rdy_q && !pix_go;
    assign BUSY      = (state != IDLE);
    assign FSM_STATE = state;

    assign ram.RAM_REQ   = req_q;
    assign ram.RAM_WE    = we_q;
    assign ram.RAM_ADDR  = addr_q;
    assign ram.RAM_WDATA = wdata_q;

    always_ff @(posedge CLK10 or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            X       <= 8'h00;
            Y       <= 8'h00;
            BD_OUT  <= 8'h00;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            is_wr   <= 1'b0;
            sel_hi  <= 1'b0;
            wn      <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (BA)
                            2'd0: begin
                                if (!BRWn) X <= BD_IN;
                                else       BD_OUT <= X;
                            end
                            2'd1: begin
                                if (!BRWn) Y <= BD_IN;
                                else       BD_OUT <= Y;
                            end
                            2'd2: begin
                                addr_q <= ADDR_W'({Y, X[7:1]});
                                sel_hi <= (X[0] == HI_NIB_ODD);
                                wn     <= BD_IN[3:0];
                                is_wr  <= !BRWn;
                                req_q  <= 1'b1;
                                we_q   <= 1'b0;
                                rdy_q  <= 1'b0;
                                state  <= RD_REQ;
                            end
                            default: begin
                                if (BRWn) BD_OUT <= 8'hFF;
                            end
                        endcase
                    end
                end
                RD_REQ: begin
                    if (gnt_ok) begin
                        req_q <= 1'b0;
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (is_wr) begin
                        wdata_q <= merged;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state   <= WR_REQ;
                    end else begin
                        BD_OUT <= {rd_nib, rd_nib};
                        state  <= STEP;
                    end
                end
                WR_REQ: begin
                    if (gnt_ok) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= STEP;
                    end
                end
                STEP: begin
                    // 8-bit arithmetic wraps naturally at both ends.
                    if (!XINCn) X <= AXn ? X + 8'd1 : X - 8'd1;
                    if (!YINCn) Y <= AYn ? Y + 8'd1 : Y - 8'd1;
                    rdy_q <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmode_seq.sv
module tb_bitmode_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_stb;
    logic       bitmd_n;
    logic [1:0] ba;
    logic       brw_n;
    logic [7:0] bd_in;
    logic [7:0] bd_out;
    logic       cpu_rdy;
    logic       xinc_n, yinc_n, ax_n, ay_n;
    logic [7:0] x_o, y_o;
    logic       busy;
    logic [2:0] fsm_state;

    int errors = 0;
    int checks = 0;

    // scoreboard queues
    logic [7:0]  exp_q[$];     // expected pixel read data
    logic [22:0] wexp_q[$];    // expected RAM writes {addr, data}
    logic [22:0] wr_obs_q[$];  // observed RAM writes {addr, data}

    // RAM / arbiter model state
    logic [7:0]  mem [0:32767];
    logic [14:0] g_addr;
    logic [7:0]  g_wdata;
    logic        g_we;
    logic [14:0] rd_addr_last;
    int          req_cycles;
    int          stall_rd;
    int          stall_wr;

    // bench model of X/Y
    logic [7:0] x_m, y_m;

    bitmode_seq_if #(.ADDR_W(15)) ram_bus ();

    bitmode_seq #(.ADDR_W(15), .HI_NIB_ODD(1'b1)) dut (
        .CLK10     (clk),
        .RESETn    (rst_n),
        .CPU_STB   (cpu_stb),
        .BITMDn    (bitmd_n),
        .BA        (ba),
        .BRWn      (brw_n),
        .BD_IN     (bd_in),
        .BD_OUT    (bd_out),
        .CPU_RDY   (cpu_rdy),
        .XINCn     (xinc_n),
        .YINCn     (yinc_n),
        .AXn       (ax_n),
        .AYn       (ay_n),
        .ram       (ram_bus),
        .X         (x_o),
        .Y         (y_o),
        .BUSY      (busy),
        .FSM_STATE (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- arbiter / RAM responder ----------------
    // Grant is raised at a negedge so the DUT samples it on the next posedge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_bus.RAM_GNT = 1'b0;
        end else if (ram_bus.RAM_GNT) begin
            ram_bus.RAM_GNT = 1'b0;
            if (g_we) begin
                mem[g_addr] = g_wdata;
                wr_obs_q.push_back({g_addr, g_wdata});
            end else begin
                ram_bus.RAM_RDATA = mem[g_addr];
                rd_addr_last      = g_addr;
            end
        end else if (ram_bus.RAM_REQ) begin
            req_cycles++;
            if (!ram_bus.RAM_WE && stall_rd > 0) begin
                stall_rd--;
            end else if (ram_bus.RAM_WE && stall_wr > 0) begin
                stall_wr--;
            end else begin
                ram_bus.RAM_GNT = 1'b1;
                g_we    = ram_bus.RAM_WE;
                g_addr  = ram_bus.RAM_ADDR;
                g_wdata = ram_bus.RAM_WDATA;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] step_val(input logic [7:0] v, input logic inc_n, input logic a_n);
        if (inc_n) return v;
        return a_n ? v + 8'd1 : v - 8'd1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic reg_access(input logic [1:0] b, input logic rwn, input logic [7:0] d);
        @(negedge clk);
        cpu_stb = 1'b1; bitmd_n = 1'b0; ba = b; brw_n = rwn; bd_in = d;
        #1 check("reg_rdy_high", cpu_rdy, 1'b1);
        @(posedge clk);
        #1 cpu_stb = 1'b0; bitmd_n = 1'b1;
        if (!rwn && b == 2'd0) x_m = d;
        if (!rwn && b == 2'd1) y_m = d;
    endtask

    task automatic pix_access(input logic rwn, input logic [7:0] d, input bit intrude,
                              output int lat, output int addr_bad);
        logic [14:0] a;
        logic [7:0]  b;
        logic [3:0]  nib;
        a = {y_m, x_m[7:1]};
        b = mem[a];
        if (rwn) begin
            nib = x_m[0] ? b[7:4] : b[3:0];
            exp_q.push_back({nib, nib});
        end else begin
            wexp_q.push_back({a, (x_m[0] ? {d[3:0], b[3:0]} : {b[7:4], d[3:0]})});
        end
        @(negedge clk);
        cpu_stb = 1'b1; bitmd_n = 1'b0; ba = 2'd2; brw_n = rwn; bd_in = d;
        #1 check("rdy_drop_on_accept", cpu_rdy, 1'b0);
        @(posedge clk);
        #1 cpu_stb = 1'b0; bitmd_n = 1'b1;
        lat = 0;
        addr_bad = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (ram_bus.RAM_REQ && ram_bus.RAM_ADDR !== a) addr_bad++;
            if (cpu_rdy) break;
            if (intrude && lat == 2) begin
                cpu_stb = 1'b1; bitmd_n = 1'b0; ba = 2'd0; brw_n = 1'b0; bd_in = 8'h77;
            end else begin
                cpu_stb = 1'b0; bitmd_n = 1'b1;
            end
        end
        cpu_stb = 1'b0; bitmd_n = 1'b1;
        x_m = step_val(x_m, xinc_n, ax_n);
        y_m = step_val(y_m, yinc_n, ay_n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check(tag, bd_out, e);
    endtask

    task automatic check_write(input string tag);
        logic [22:0] e;
        logic [22:0] o;
        e = wexp_q.pop_front();
        check({tag, "_count"}, wr_obs_q.size(), 1);
        o = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 23'h0;
        check(tag, o, e);
        wr_obs_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int abad;
        int wait_n;
        logic [7:0] rx, ry, rd;

        rst_n = 1'b0;
        cpu_stb = 1'b0; bitmd_n = 1'b1; ba = 2'd0; brw_n = 1'b1; bd_in = 8'h00;
        xinc_n = 1'b1; yinc_n = 1'b1; ax_n = 1'b1; ay_n = 1'b1;
        ram_bus.RAM_GNT = 1'b0;
        ram_bus.RAM_RDATA = 8'h00;
        g_addr = '0; g_wdata = '0; g_we = 1'b0; rd_addr_last = '0;
        req_cycles = 0; stall_rd = 0; stall_wr = 0;
        x_m = 8'h00; y_m = 8'h00;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom_range(0, 255));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", x_o, 8'h00);
        check("rst_y", y_o, 8'h00);
        check("rst_bd_out", bd_out, 8'h00);
        check("rst_cpu_rdy", cpu_rdy, 1'b1);
        check("rst_ram_req", ram_bus.RAM_REQ, 1'b0);
        check("rst_ram_we", ram_bus.RAM_WE, 1'b0);
        check("rst_ram_wdata", ram_bus.RAM_WDATA, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // register load / readback
        reg_access(2'd0, 1'b0, 8'h12);
        reg_access(2'd1, 1'b0, 8'h34);
        reg_access(2'd0, 1'b1, 8'h00);
        check("read_x", bd_out, 8'h12);
        reg_access(2'd1, 1'b1, 8'h00);
        check("read_y", bd_out, 8'h34);
        reg_access(2'd3, 1'b1, 8'h00);
        check("read_ba3", bd_out, 8'hFF);
        reg_access(2'd3, 1'b0, 8'h55);
        check("write_ba3_x", x_o, 8'h12);
        check("write_ba3_y", y_o, 8'h34);
        check("reg_no_ram_req", req_cycles, 0);

        // pixel read, immediate grant
        reg_access(2'd0, 1'b0, 8'h05);
        reg_access(2'd1, 1'b0, 8'h10);
        mem[15'h0802] = 8'hA7;
        pix_access(1'b1, 8'h00, 1'b0, lat, abad);
        check_read("pix_read_hi");
        check("pix_read_addr", rd_addr_last, 15'h0802);
        check("pix_read_lat", lat, 4);
        check("pix_read_x_hold", x_o, 8'h05);
        check("pix_read_y_hold", y_o, 8'h10);

        // pixel write RMW, low nibble; upper BD_IN bits must not leak in
        reg_access(2'd0, 1'b0, 8'h04);
        pix_access(1'b0, 8'hF3, 1'b0, lat, abad);
        check_write("pix_write_lo");
        check("pix_write_lat", lat, 5);
        check("pix_write_mem", mem[15'h0802], 8'hA3);

        // pixel write, high nibble
        reg_access(2'd0, 1'b0, 8'h05);
        pix_access(1'b0, 8'h09, 1'b0, lat, abad);
        check_write("pix_write_hi");
        check("pix_write_hi_mem", mem[15'h0802], 8'h93);

        // random pixel writes then read back, with stepping active
        xinc_n = 1'b0; ax_n = 1'b1; yinc_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            reg_access(2'd0, 1'b0, rx);
            reg_access(2'd1, 1'b0, ry);
            pix_access(1'b0, rd, 1'b0, lat, abad);
            check_write("rand_write");
            check("rand_write_x_step", x_o, x_m);
            pix_access(1'b1, 8'h00, 1'b0, lat, abad);
            check_read("rand_read");
        end

        // step and wrap: X 0xFF -> 0x00 (+1), Y 0x00 -> 0xFF (-1)
        xinc_n = 1'b0; ax_n = 1'b1; yinc_n = 1'b0; ay_n = 1'b0;
        reg_access(2'd0, 1'b0, 8'hFF);
        reg_access(2'd1, 1'b0, 8'h00);
        mem[15'h007F] = 8'h3E;
        pix_access(1'b1, 8'h00, 1'b0, lat, abad);
        check_read("wrap_read");
        check("wrap_x", x_o, 8'h00);
        check("wrap_y", y_o, 8'hFF);

        // step Y upward, X downward, no wrap
        ax_n = 1'b0; ay_n = 1'b1;
        reg_access(2'd0, 1'b0, 8'h40);
        reg_access(2'd1, 1'b0, 8'h20);
        pix_access(1'b1, 8'h00, 1'b0, lat, abad);
        check_read("step_read");
        check("step_x_dec", x_o, 8'h3F);
        check("step_y_inc", y_o, 8'h21);

        // steps disabled
        xinc_n = 1'b1; yinc_n = 1'b1;
        pix_access(1'b1, 8'h00, 1'b0, lat, abad);
        check_read("nostep_read");
        check("nostep_x", x_o, 8'h3F);
        check("nostep_y", y_o, 8'h21);

        // grant stall of 6 cycles with an intruding CPU strobe while busy
        stall_rd = 6;
        pix_access(1'b1, 8'h00, 1'b1, lat, abad);
        check_read("stall_read");
        check("stall_lat", lat, 10);
        check("stall_addr_stable", abad, 0);
        check("stall_intrude_x", x_o, 8'h3F);

        // reset while waiting in WR_REQ
        reg_access(2'd0, 1'b0, 8'h20);
        reg_access(2'd1, 1'b0, 8'h30);
        stall_wr = 1000;
        @(negedge clk);
        cpu_stb = 1'b1; bitmd_n = 1'b0; ba = 2'd2; brw_n = 1'b0; bd_in = 8'h06;
        @(posedge clk);
        #1 cpu_stb = 1'b0; bitmd_n = 1'b1;
        wait_n = 0;
        while (fsm_state != 3'd3 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("reached_wr_req", ram_bus.RAM_WE && ram_bus.RAM_REQ, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ram_req", ram_bus.RAM_REQ, 1'b0);
        check("midrst_x", x_o, 8'h00);
        check("midrst_y", y_o, 8'h00);
        check("midrst_cpu_rdy", cpu_rdy, 1'b1);
        check("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("midrst_no_write", wr_obs_q.size(), 0);
        stall_wr = 0;
        x_m = 8'h00; y_m = 8'h00;
        rst_n = 1'b1;
        mem[15'h0000] = 8'h5C;
        pix_access(1'b1, 8'h00, 1'b0, lat, abad);
        check_read("post_rst_read");
        check("post_rst_lat", lat, 4);
        check("post_rst_addr", rd_addr_last, 15'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitmode_seq.md
Name: bitmode_seq

Overview:
- Sequences Crystal Castles "bitmode" pixel accesses, issued by the CPU through the bitmap window.
- Holds the X/Y pixel address registers and converts a CPU pixel read/write into a RAM byte read (or read-modify-write) of the selected nibble.
- Requests the shared video RAM port from the RAM arbiter and post-steps X/Y according to the XINCn/YINCn/AXn/AYn latch bits.
- Sits between the address decoder outputs (BITMDn, BRWn, latch bits) and the video RAM arbiter.

Parameters:
- ADDR_W, 15, RAM byte address width; RAM_ADDR = {Y[7:0], X[7:1]} zero-extended to ADDR_W.
- HI_NIB_ODD, 1, 1: X[0]=1 selects bits [7:4]; 0: X[0]=1 selects bits [3:0].

Ports:
- CLK10  in  1  system clock.
- RESETn  in  1  asynchronous active-low reset.
- CPU_STB  in  1  one-cycle strobe marking a valid CPU bus cycle (sample point for all CPU inputs).
- BITMDn  in  1  active-low select of the bitmode register window.
- BA  in  2  register select: 0=X, 1=Y, 2=pixel, 3=reserved.
- BRWn  in  1  1=read, 0=write.
- BD_IN  in  8  CPU write data.
- BD_OUT  out  8  CPU read data.
- CPU_RDY  out  1  low stalls the CPU while a pixel access is in progress.
- XINCn, YINCn  in  1 each  active-low step enables.
- AXn, AYn  in  1 each  step direction: 1=+1, 0=-1.
- RAM_REQ  out  1  RAM port request.
- RAM_GNT  in  1  arbiter grant, one cycle.
- RAM_WE  out  1  1=write cycle, qualified by RAM_REQ.
- RAM_ADDR  out  ADDR_W  byte address.
- RAM_WDATA  out  8  write data.
- RAM_RDATA  in  8  read data, valid the cycle after the read grant.
- X, Y  out  8 each  current pixel address registers.
- BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, any state): X=Y=0, BD_OUT=0, CPU_RDY=1, RAM_REQ=0, RAM_WE=0, RAM_WDATA=0, BUSY=0, FSM=IDLE. An in-flight RAM request is abandoned. The arbiter must drop the grant on the same reset.
- CPU accesses are accepted only in IDLE, with CPU_STB=1 and BITMDn=0.
- BA=0/1 write: load X/Y from BD_IN at that edge. No RAM cycle, no step.
- BA=0/1 read: BD_OUT=X/Y registered at that edge. CPU_RDY stays 1.
- BA=3: writes ignored; reads return 8'hFF.
- BA=2: CPU_RDY drops combinationally with acceptance and the FSM starts a sequence. The address is latched at acceptance as A={Y,X[7:1]}, together with nibble select s=X[0] and, for writes, wn=BD_IN[3:0].
- FSM states:
  - IDLE.
  - RD_REQ: RAM_REQ=1, RAM_WE=0, RAM_ADDR=A. Hold until RAM_GNT=1, then go to RD_DATA.
  - RD_DATA: capture RAM_RDATA into byte register b.
    - Read: BD_OUT={nib,nib}, where nib is the selected nibble of b; go to STEP.
    - Write: go to WR_REQ.
  - WR_REQ: RAM_REQ=1, RAM_WE=1, RAM_ADDR=A, RAM_WDATA=b with the selected nibble replaced by wn. Hold until RAM_GNT=1, then go to STEP.
  - STEP: if XINCn=0, X<=X+1 when AXn=1, else X-1. Same rule for Y. Arithmetic is mod 256; 8'hFF+1 wraps to 0 and 0-1 wraps to 8'hFF. Step-control bits are sampled in STEP. Go to DONE.
  - DONE: CPU_RDY=1 for exactly one cycle; return to IDLE.
- RAM_REQ/RAM_WE/RAM_ADDR/RAM_WDATA are registered and stable while waiting for the grant. A grant seen while RAM_REQ=0 is ignored.
- Latency with the grant returned on the first request cycle: read = 4 cycles from acceptance to DONE; write = 5 cycles. Each grant-wait cycle adds 1.
- CPU_STB arriving while BUSY is ignored; the CPU is stalled by CPU_RDY.
- The other bytes' nibble is preserved bit-exact on writes.

Test Plan:
- Reg load/readback: write X=0x12, Y=0x34, then read BA=0 and BA=1 -> BD_OUT 0x12, 0x34; no RAM_REQ.
- Pixel read, immediate grant: X=0x05, Y=0x10, RAM[0x0802]=0xA7, HI_NIB_ODD=1, read BA=2 -> RAM_ADDR=0x0802, BD_OUT=0xAA; CPU_RDY low 3 cycles then high 1 cycle.
- Pixel write RMW: X=0x04, Y=0x10, RAM[0x0802]=0xA7, write BA=2 data 0x3 -> single write cycle of 0xA3 to 0x0802.
- Step and wrap: XINCn=0, AXn=1, X=0xFF, YINCn=0, AYn=0, Y=0x00, pixel read -> X=0x00, Y=0xFF after DONE. With XINCn=YINCn=1 -> X/Y unchanged.
- Grant stall: hold RAM_GNT=0 for 6 cycles in RD_REQ -> RAM_REQ/RAM_ADDR stable, CPU_RDY low throughout, completes 6 cycles later than nominal.
- Reset mid-write: assert RESETn=0 during WR_REQ -> RAM_REQ=0 immediately, X=Y=0, CPU_RDY=1, no RAM write; after release, a new pixel read runs normally.
